// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared opcodes, state encoding and mul/div decode helpers
package pipeline_stall_controller_pkg;

  localparam logic [4:0] OP_R_TYPE = 5'd0;
  localparam logic [4:0] OP_J      = 5'd1;
  localparam logic [4:0] OP_BNE    = 5'd2;
  localparam logic [4:0] OP_JAL    = 5'd3;
  localparam logic [4:0] OP_JR     = 5'd4;
  localparam logic [4:0] OP_ADDI   = 5'd5;
  localparam logic [4:0] OP_BLT    = 5'd6;
  localparam logic [4:0] OP_SW     = 5'd7;
  localparam logic [4:0] OP_LW     = 5'd8;
  localparam logic [4:0] OP_SETX   = 5'd21;
  localparam logic [4:0] OP_BEX    = 5'd22;

  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  localparam logic [31:0] NOP = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  // Opcode lives in [31:27], ALU op in [6:2] for R-type instructions.
  function automatic logic is_mul(input logic [31:0] instr);
    return (instr[31:27] == OP_R_TYPE) && (instr[6:2] == ALU_MUL);
  endfunction

  function automatic logic is_div(input logic [31:0] instr);
    return (instr[31:27] == OP_R_TYPE) && (instr[6:2] == ALU_DIV);
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_md_sequencer.sv
// rtl/pipeline_stall_controller_md_sequencer.sv - mul/div FSM, cycle/timeout counter and result capture
module md_sequencer
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7   // 2**CNT_W must exceed MD_TIMEOUT
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start_mul,
  input  logic             i_start_div,
  input  logic             i_md_ready,
  input  logic             i_md_exception,
  input  logic [31:0]      i_md_result,
  output md_state_t        o_state,
  output logic             o_ctrl_mult,
  output logic             o_ctrl_div,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic [31:0]      o_result_q,
  output logic             o_error_q,
  output logic [CNT_W-1:0] o_cycles
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX      = '1;

  md_state_t        r_state;
  logic             r_ctrl_mult;
  logic             r_ctrl_div;
  logic             r_busy;
  logic             r_result_valid;
  logic [31:0]      r_result_q;
  logic             r_error_q;
  logic [CNT_W-1:0] r_cycles;

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state        <= ST_IDLE;
      r_ctrl_mult    <= 1'b0;
      r_ctrl_div     <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_q     <= 32'd0;
      r_error_q      <= 1'b0;
      r_cycles       <= '0;
    end else begin
      r_ctrl_mult    <= 1'b0;
      r_ctrl_div     <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start_mul || i_start_div) begin
            r_state     <= ST_START;
            r_ctrl_mult <= i_start_mul;
            r_ctrl_div  <= i_start_div && !i_start_mul;
            r_busy      <= 1'b1;
          end
        end
        ST_START: begin
          r_state  <= ST_BUSY;
          r_cycles <= '0;
        end
        ST_BUSY: begin
          if (r_cycles != LP_CNT_MAX) begin
            r_cycles <= r_cycles + CNT_W'(1);
          end
          // A result arriving on the timeout cycle still counts as a result.
          if (i_md_ready) begin
            r_state        <= ST_DONE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
            r_result_q     <= i_md_result;
            r_error_q      <= i_md_exception;
          end else if (r_cycles == LP_TIMEOUT_LAST) begin
            r_state        <= ST_DONE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
            r_result_q     <= 32'd0;
            r_error_q      <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_ctrl_mult    = r_ctrl_mult;
  assign o_ctrl_div     = r_ctrl_div;
  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_result_q     = r_result_q;
  assign o_error_q      = r_error_q;
  assign o_cycles       = r_cycles;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - latch enables, bubble/flush control and mul/div sequencing top
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic [31:0]      DX_Latch_Instr,
  input  logic             branch_taken,
  input  logic             md_ready,
  input  logic             md_exception,
  input  logic [31:0]      md_result,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             PC_write_en,
  output logic             FD_write_en,
  output logic             DX_write_en,
  output logic             FD_flush,
  output logic             DX_insert_nop,
  output logic             XM_insert_nop,
  output logic             md_result_valid,
  output logic [31:0]      md_result_q,
  output logic             md_error_q,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cycles
);

  logic      w_is_mul;
  logic      w_is_div;
  md_state_t w_state;

  assign w_is_mul = is_mul(DX_Latch_Instr);
  assign w_is_div = is_div(DX_Latch_Instr);

  md_sequencer #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_md_sequencer (
    .i_clock        (clock),
    .i_reset_n      (reset),
    .i_start_mul    (w_is_mul),
    .i_start_div    (w_is_div),
    .i_md_ready     (md_ready),
    .i_md_exception (md_exception),
    .i_md_result    (md_result),
    .o_state        (w_state),
    .o_ctrl_mult    (ctrl_MULT),
    .o_ctrl_div     (ctrl_DIV),
    .o_busy         (md_busy),
    .o_result_valid (md_result_valid),
    .o_result_q     (md_result_q),
    .o_error_q      (md_error_q),
    .o_cycles       (md_cycles)
  );

  // Latch enables and bubble controls; mul/div in DX outranks branch, branch outranks load-use.
  always_comb begin
    PC_write_en   = 1'b1;
    FD_write_en   = 1'b1;
    DX_write_en   = 1'b1;
    FD_flush      = 1'b0;
    DX_insert_nop = 1'b0;
    XM_insert_nop = 1'b0;
    case (w_state)
      ST_IDLE: begin
        if (w_is_mul || w_is_div) begin
          PC_write_en   = 1'b0;
          FD_write_en   = 1'b0;
          DX_write_en   = 1'b0;
          XM_insert_nop = 1'b1;
        end else if (branch_taken) begin
          FD_flush      = 1'b1;
          DX_insert_nop = 1'b1;
        end else if (load_use_stall) begin
          PC_write_en   = 1'b0;
          FD_write_en   = 1'b0;
          DX_insert_nop = 1'b1;
        end
      end
      ST_START, ST_BUSY: begin
        PC_write_en   = 1'b0;
        FD_write_en   = 1'b0;
        DX_write_en   = 1'b0;
        XM_insert_nop = 1'b1;
      end
      default: begin
        // DONE: everything advances so XM captures the mul/div with its result.
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 7;

  logic             clock;
  logic             reset;
  logic             load_use_stall;
  logic [31:0]      DX_Latch_Instr;
  logic             branch_taken;
  logic             md_ready;
  logic             md_exception;
  logic [31:0]      md_result;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             PC_write_en;
  logic             FD_write_en;
  logic             DX_write_en;
  logic             FD_flush;
  logic             DX_insert_nop;
  logic             XM_insert_nop;
  logic             md_result_valid;
  logic [31:0]      md_result_q;
  logic             md_error_q;
  logic             md_busy;
  logic [CNT_W-1:0] md_cycles;

  pipeline_stall_controller #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .load_use_stall  (load_use_stall),
    .DX_Latch_Instr  (DX_Latch_Instr),
    .branch_taken    (branch_taken),
    .md_ready        (md_ready),
    .md_exception    (md_exception),
    .md_result       (md_result),
    .ctrl_MULT       (ctrl_MULT),
    .ctrl_DIV        (ctrl_DIV),
    .PC_write_en     (PC_write_en),
    .FD_write_en     (FD_write_en),
    .DX_write_en     (DX_write_en),
    .FD_flush        (FD_flush),
    .DX_insert_nop   (DX_insert_nop),
    .XM_insert_nop   (XM_insert_nop),
    .md_result_valid (md_result_valid),
    .md_result_q     (md_result_q),
    .md_error_q      (md_error_q),
    .md_busy         (md_busy),
    .md_cycles       (md_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic mult;
    logic div;
    logic pc_we;
    logic fd_we;
    logic dx_we;
    logic fd_flush;
    logic dx_nop;
    logic xm_nop;
    logic res_valid;
    logic busy;
  } ctl_t;

  typedef struct {
    logic             chk;
    ctl_t             ctl;
    logic [31:0]      res;
    logic             err;
    logic [CNT_W-1:0] cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               vectors     = 0;
  int               miscompares = 0;

  // Reference model's view of the held result registers and cycle count.
  logic [31:0]      m_res;
  logic             m_err;
  logic [CNT_W-1:0] m_cyc;

  ctl_t             mon_obs;
  exp_t             mon_e;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic chk, input ctl_t c);
    exp_t e;
    e.chk = chk;
    e.ctl = c;
    e.res = m_res;
    e.err = m_err;
    e.cyc = m_cyc;
    sb_q.push_back(e);
  endtask

  function automatic ctl_t ctl_idle(input logic lus, input logic br);
    ctl_t c;
    c = '0;
    c.dx_we = 1'b1;
    if (br) begin
      c.pc_we = 1'b1; c.fd_we = 1'b1; c.fd_flush = 1'b1; c.dx_nop = 1'b1;
    end else if (lus) begin
      c.dx_nop = 1'b1;
    end else begin
      c.pc_we = 1'b1; c.fd_we = 1'b1;
    end
    return c;
  endfunction

  function automatic ctl_t ctl_hold();
    ctl_t c;
    c = '0;
    c.xm_nop = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[31:27] = 5'd0;
    if (w[31:27] == 5'd0 && (w[6:2] == 5'd6 || w[6:2] == 5'd7)) w[6:2] = 5'd5;
    return w;
  endfunction

  function automatic logic [31:0] rand_md(input logic is_div);
    logic [31:0] w;
    w = $urandom;
    w[31:27] = 5'd0;
    w[6:2]   = is_div ? 5'd7 : 5'd6;
    return w;
  endfunction

  task automatic spurious();
    md_ready     = 1'($urandom_range(0, 1));
    md_result    = $urandom;
    md_exception = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle(input logic lus, input logic br, input logic rdy);
    step();
    DX_Latch_Instr = rand_plain();
    load_use_stall = lus;
    branch_taken   = br;
    md_ready       = rdy;
    md_result      = $urandom;
    md_exception   = 1'($urandom_range(0, 1));
    push(1'b1, ctl_idle(lus, br));
  endtask

  task automatic idle_rand();
    idle_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
  endtask

  // One mul/div: detect in IDLE, START, k BUSY cycles, DONE.
  task automatic run_op(input logic is_div, input int n, input logic exc,
                        input logic [31:0] res, input logic to);
    ctl_t c;
    int   k_last;
    k_last = to ? MD_TIMEOUT : n;
    step();
    DX_Latch_Instr = rand_md(is_div);
    load_use_stall = 1'($urandom_range(0, 1));
    branch_taken   = 1'($urandom_range(0, 1));
    spurious();
    push(1'b1, ctl_hold());
    step();
    load_use_stall = 1'($urandom_range(0, 1));
    branch_taken   = 1'($urandom_range(0, 1));
    spurious();
    c = ctl_hold();
    c.mult = !is_div;
    c.div  = is_div;
    c.busy = 1'b1;
    push(1'b1, c);
    for (int k = 1; k <= k_last; k++) begin
      step();
      load_use_stall = 1'($urandom_range(0, 1));
      branch_taken   = 1'($urandom_range(0, 1));
      md_ready       = !to && (k == n);
      md_result      = md_ready ? res : $urandom;
      md_exception   = md_ready ? exc : 1'($urandom_range(0, 1));
      m_cyc          = CNT_W'(k - 1);
      c = ctl_hold();
      c.busy = 1'b1;
      push(1'b1, c);
    end
    step();
    spurious();
    m_res = to ? 32'd0 : res;
    m_err = to ? 1'b1 : exc;
    m_cyc = CNT_W'(k_last);
    c = '0;
    c.pc_we = 1'b1; c.fd_we = 1'b1; c.dx_we = 1'b1; c.res_valid = 1'b1;
    push(1'b1, c);
  endtask

  // Reset in the middle of BUSY with an md_ready in flight and right after.
  task automatic run_reset_mid();
    ctl_t c;
    step();
    DX_Latch_Instr = rand_md(1'b0);
    load_use_stall = 1'b0; branch_taken = 1'b0; md_ready = 1'b0;
    push(1'b1, ctl_hold());
    step();
    c = ctl_hold(); c.mult = 1'b1; c.busy = 1'b1;
    push(1'b1, c);
    for (int k = 1; k <= 5; k++) begin
      step();
      m_cyc = CNT_W'(k - 1);
      c = ctl_hold(); c.busy = 1'b1;
      push(1'b1, c);
    end
    step();
    reset = 1'b0; md_ready = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
    push(1'b0, '0);
    step();
    md_ready = 1'b0;
    push(1'b0, '0);
    m_res = 32'd0; m_err = 1'b0; m_cyc = '0;
    step();
    reset = 1'b1;
    DX_Latch_Instr = rand_plain();
    md_ready = 1'b1; md_result = 32'h1234_5678; md_exception = 1'b1;
    push(1'b1, ctl_idle(1'b0, 1'b0));
    idle_cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: one expected entry per cycle, compared at the falling edge.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_obs = {ctrl_MULT, ctrl_DIV, PC_write_en, FD_write_en, DX_write_en,
                 FD_flush, DX_insert_nop, XM_insert_nop, md_result_valid, md_busy};
      if (mon_e.chk) begin
        vectors++;
        if (mon_obs !== mon_e.ctl) begin
          miscompares++;
          $display("FAIL ctrl t=%0t got=%b exp=%b (mult div pc fd dx flush dxnop xmnop valid busy)",
                   $time, mon_obs, mon_e.ctl);
        end
        vectors++;
        if (md_result_q !== mon_e.res || md_error_q !== mon_e.err) begin
          miscompares++;
          $display("FAIL result t=%0t got=%h/%b exp=%h/%b", $time, md_result_q, md_error_q,
                   mon_e.res, mon_e.err);
        end
        vectors++;
        if (md_cycles !== mon_e.cyc) begin
          miscompares++;
          $display("FAIL md_cycles t=%0t got=%0d exp=%0d", $time, md_cycles, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; load_use_stall = 1'b0; branch_taken = 1'b0;
    DX_Latch_Instr = 32'd0; md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    m_res = 32'd0; m_err = 1'b0; m_cyc = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    push(1'b1, ctl_idle(1'b0, 1'b0));
    idle_cycle(1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1, 1'b1);
    run_op(1'b0, 16, 1'b0, 32'h0000_0F00, 1'b0);
    idle_cycle(1'b0, 1'b0, 1'b0);
    run_op(1'b1, 5, 1'b1, 32'hCAFE_0001, 1'b0);
    run_op(1'b1, 1, 1'b0, 32'h0, 1'b1);
    run_op(1'b0, 9, 1'b0, 32'h0000_1111, 1'b0);
    run_op(1'b1, 3, 1'b0, 32'h0000_2222, 1'b0);
    run_op(1'b0, 64, 1'b0, 32'h0BAD_F00D, 1'b0);
    run_op(1'b0, 1, 1'b1, 32'h7777_0000, 1'b0);
    run_reset_mid();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        run_op(1'($urandom_range(0, 1)), int'($urandom_range(1, MD_TIMEOUT)),
               1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 5) == 0));
      end else begin
        idle_rand();
      end
    end
    @(negedge clock);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
